// File: rtl/force_release_pkg.sv
// Shared types and helpers for the force/release register block.
package force_release_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCED = 1'b1
    } fr_state_t;

    localparam int MODE_HOLD    = 0;
    localparam int MODE_RESTORE = 1;

    // Width of a counter that must represent 0..n; callers only instantiate it for n > 0.
    function automatic int timer_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/force_release_chan.sv
// One channel: NORMAL/FORCED FSM, shadow of the last loaded value and optional auto-release timer.
module force_release_chan
    import force_release_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               RELEASE_MODE  = MODE_HOLD,
    parameter int               FORCE_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             force_clr,
    input  logic             force_set,
    input  logic             force_val,
    input  logic [WIDTH-1:0] force_data,
    input  logic             release_in,
    output logic [WIDTH-1:0] state,
    output logic             forced,
    output logic             expired
);

    fr_state_t        fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             expired_q, expired_d;
    logic             any_force;
    logic [WIDTH-1:0] force_value;
    logic             timeout_hit;

    assign any_force   = force_clr | force_set | force_val;
    assign force_value = force_clr ? '0 : (force_set ? '1 : force_data);

    generate
        if (FORCE_TIMEOUT > 0) begin : g_timer
            localparam int             TW   = timer_width(FORCE_TIMEOUT);
            localparam logic [TW-1:0]  LAST = TW'(FORCE_TIMEOUT - 1);

            logic [TW-1:0] timer_q, timer_d;

            // Timer holds the number of forced cycles already completed; saturates at all-ones.
            always_comb begin
                timer_d = timer_q;
                if (any_force || fsm_q != ST_FORCED) begin
                    timer_d = '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_d;
                end
            end

            assign timeout_hit = (fsm_q == ST_FORCED) && (timer_q == LAST);
        end else begin : g_no_timer
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        shadow_d  = shadow_q;
        expired_d = 1'b0;
        if (load) begin
            shadow_d = data_in;
        end
        if (any_force) begin
            fsm_d   = ST_FORCED;
            state_d = force_value;
        end else if (fsm_q == ST_FORCED) begin
            if (release_in || timeout_hit) begin
                fsm_d     = ST_NORMAL;
                expired_d = ~release_in;
                if (RELEASE_MODE == MODE_RESTORE) begin
                    state_d = load ? data_in : shadow_q;
                end
            end
        end else if (load) begin
            state_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            fsm_q     <= ST_NORMAL;
            state_q   <= RESET_VAL;
            shadow_q  <= RESET_VAL;
            expired_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            expired_q <= expired_d;
        end
    end

    assign state   = state_q;
    assign forced  = (fsm_q == ST_FORCED);
    assign expired = expired_q;

endmodule

// File: rtl/force_release_reg.sv
// NCH independent force/release registers; the top only slices the buses per channel.
module force_release_reg
    import force_release_pkg::*;
#(
    parameter int               NCH           = 4,
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               RELEASE_MODE  = MODE_HOLD,
    parameter int               FORCE_TIMEOUT = 0
) (
    input  logic                 CLOCK,
    input  logic                 RST,
    input  logic [NCH-1:0]       LOAD,
    input  logic [NCH*WIDTH-1:0] DATA_IN,
    input  logic [NCH-1:0]       FORCE_CLR,
    input  logic [NCH-1:0]       FORCE_SET,
    input  logic [NCH-1:0]       FORCE_VAL,
    input  logic [NCH*WIDTH-1:0] FORCE_DATA,
    input  logic [NCH-1:0]       RELEASE,
    output logic [NCH*WIDTH-1:0] STATE,
    output logic [NCH-1:0]       FORCED,
    output logic [NCH-1:0]       EXPIRED
);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            force_release_chan #(
                .WIDTH         (WIDTH),
                .RESET_VAL     (RESET_VAL),
                .RELEASE_MODE  (RELEASE_MODE),
                .FORCE_TIMEOUT (FORCE_TIMEOUT)
            ) u_chan (
                .clk        (CLOCK),
                .srst       (RST),
                .load       (LOAD[gi]),
                .data_in    (DATA_IN[gi*WIDTH +: WIDTH]),
                .force_clr  (FORCE_CLR[gi]),
                .force_set  (FORCE_SET[gi]),
                .force_val  (FORCE_VAL[gi]),
                .force_data (FORCE_DATA[gi*WIDTH +: WIDTH]),
                .release_in (RELEASE[gi]),
                .state      (STATE[gi*WIDTH +: WIDTH]),
                .forced     (FORCED[gi]),
                .expired    (EXPIRED[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_force_release_reg.sv
// Bench: two configurations (restore/no timeout, hold/timeout 3) driven by shared stimulus,
// checked every cycle against a behavioural model plus literal spot checks.
module tb_force_release_reg;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam logic [7:0] RV = 8'h5A;
    localparam int RM [2] = '{1, 0};
    localparam int TO [2] = '{0, 3};

    logic          CLOCK = 1'b0;
    logic          RST = 1'b1;
    logic [3:0]    LOAD = '0, FORCE_CLR = '0, FORCE_SET = '0, FORCE_VAL = '0, RELEASE = '0;
    logic [31:0]   DATA_IN = '0, FORCE_DATA = '0;
    logic [31:0]   state_a, state_b;
    logic [3:0]    forced_a, forced_b, expired_a, expired_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLOCK = ~CLOCK;

    force_release_reg #(.NCH(NCH), .WIDTH(W), .RESET_VAL(RV), .RELEASE_MODE(1), .FORCE_TIMEOUT(0)) dut_a (
        .CLOCK(CLOCK), .RST(RST), .LOAD(LOAD), .DATA_IN(DATA_IN), .FORCE_CLR(FORCE_CLR),
        .FORCE_SET(FORCE_SET), .FORCE_VAL(FORCE_VAL), .FORCE_DATA(FORCE_DATA), .RELEASE(RELEASE),
        .STATE(state_a), .FORCED(forced_a), .EXPIRED(expired_a));

    force_release_reg #(.NCH(NCH), .WIDTH(W), .RESET_VAL(RV), .RELEASE_MODE(0), .FORCE_TIMEOUT(3)) dut_b (
        .CLOCK(CLOCK), .RST(RST), .LOAD(LOAD), .DATA_IN(DATA_IN), .FORCE_CLR(FORCE_CLR),
        .FORCE_SET(FORCE_SET), .FORCE_VAL(FORCE_VAL), .FORCE_DATA(FORCE_DATA), .RELEASE(RELEASE),
        .STATE(state_b), .FORCED(forced_b), .EXPIRED(expired_b));

    // ---------------- behavioural model ----------------
    logic [7:0] m_st [2][4];
    logic [7:0] m_sh [2][4];
    bit         m_f  [2][4];
    bit         m_e  [2][4];
    int         m_n  [2][4];   // forced cycles elapsed, counting the current one
    bit         m_valid = 1'b0;

    always @(posedge CLOCK) begin
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) begin
                logic [7:0] din, fd;
                din = DATA_IN[c*8 +: 8];
                fd  = FORCE_DATA[c*8 +: 8];
                if (RST) begin
                    m_st[m][c] = RV; m_sh[m][c] = RV; m_f[m][c] = 0; m_e[m][c] = 0; m_n[m][c] = 0;
                end else begin
                    m_e[m][c] = 0;
                    if (FORCE_CLR[c] || FORCE_SET[c] || FORCE_VAL[c]) begin
                        m_st[m][c] = FORCE_CLR[c] ? 8'h00 : (FORCE_SET[c] ? 8'hFF : fd);
                        m_f[m][c]  = 1;
                        m_n[m][c]  = 1;
                        if (LOAD[c]) m_sh[m][c] = din;
                    end else if (m_f[m][c] && (RELEASE[c] || (TO[m] > 0 && m_n[m][c] == TO[m]))) begin
                        m_f[m][c] = 0;
                        m_e[m][c] = !RELEASE[c];
                        m_n[m][c] = 0;
                        if (RM[m] == 1) m_st[m][c] = LOAD[c] ? din : m_sh[m][c];
                        if (LOAD[c]) m_sh[m][c] = din;
                    end else if (m_f[m][c]) begin
                        m_n[m][c] = m_n[m][c] + 1;
                        if (LOAD[c]) m_sh[m][c] = din;
                    end else if (LOAD[c]) begin
                        m_st[m][c] = din;
                        m_sh[m][c] = din;
                    end
                end
            end
        end
        if (RST) m_valid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge CLOCK) begin
        #2;
        if (m_valid) begin
            for (int m = 0; m < 2; m++) begin
                logic [31:0] exp_s, act_s;
                logic [3:0]  exp_f, exp_e, act_f, act_e;
                act_s = (m == 0) ? state_a : state_b;
                act_f = (m == 0) ? forced_a : forced_b;
                act_e = (m == 0) ? expired_a : expired_b;
                for (int c = 0; c < NCH; c++) begin
                    exp_s[c*8 +: 8] = m_st[m][c];
                    exp_f[c] = m_f[m][c];
                    exp_e[c] = m_e[m][c];
                end
                n_vec++;
                if (act_s !== exp_s || act_f !== exp_f || act_e !== exp_e) begin
                    n_err++;
                    $display("FAIL model dut%0d t=%0t: STATE=%h FORCED=%b EXPIRED=%b expected STATE=%h FORCED=%b EXPIRED=%b",
                             m, $time, act_s, act_f, act_e, exp_s, exp_f, exp_e);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLOCK);
        #3;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        LOAD = '0; FORCE_CLR = '0; FORCE_SET = '0; FORCE_VAL = '0; RELEASE = '0;
    endtask

    initial begin
        // 1. reset
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        chk("reset_state_a", state_a, 32'h5A5A5A5A);
        chk("reset_state_b", state_b, 32'h5A5A5A5A);
        chk("reset_forced", {28'd0, forced_a | forced_b}, 32'd0);
        chk("reset_expired", {28'd0, expired_a | expired_b}, 32'd0);

        // 2/3. load, force set, load while forced, release
        LOAD = 4'b0001; DATA_IN = 32'h0000_0011; tick(); idle();
        chk("load_11", {24'd0, state_a[7:0]}, 32'h11);
        FORCE_SET = 4'b0001; tick(); idle();
        chk("forceset_ff", {24'd0, state_a[7:0]}, 32'hFF);
        chk("forceset_forced", {31'd0, forced_a[0]}, 32'd1);
        LOAD = 4'b0001; DATA_IN = 32'h0000_0022; tick(); idle();
        chk("load_while_forced", {24'd0, state_a[7:0]}, 32'hFF);
        RELEASE = 4'b0001; tick(); idle();
        chk("restore_22", {24'd0, state_a[7:0]}, 32'h22);
        chk("restore_forced0", {31'd0, forced_a[0]}, 32'd0);
        chk("hold_ff", {24'd0, state_b[7:0]}, 32'hFF);
        LOAD = 4'b0001; DATA_IN = 32'h0000_0033; tick(); idle();
        chk("hold_then_load_33", {24'd0, state_b[7:0]}, 32'h33);

        // 4. priority on ch1
        FORCE_CLR = 4'b0010; FORCE_SET = 4'b0010; RELEASE = 4'b0010; LOAD = 4'b0010;
        DATA_IN = 32'h0000_4400; tick(); idle();
        chk("prio_state", {24'd0, state_a[15:8]}, 32'h00);
        chk("prio_forced", {31'd0, forced_a[1]}, 32'd1);
        RELEASE = 4'b0010; tick(); idle();
        chk("prio_shadow_44", {24'd0, state_a[15:8]}, 32'h44);

        // 5. timeout on ch2 (dut_b)
        FORCE_VAL = 4'b0100; FORCE_DATA = 32'h00A5_0000; tick(); idle();
        chk("to_val_a5", {24'd0, state_b[23:16]}, 32'hA5);
        chk("to_f1", {31'd0, forced_b[2]}, 32'd1);
        tick(); chk("to_f2", {31'd0, forced_b[2]}, 32'd1);
        tick(); chk("to_f3", {31'd0, forced_b[2]}, 32'd1);
        tick(); chk("to_released", {31'd0, forced_b[2]}, 32'd0);
        chk("to_expired", {31'd0, expired_b[2]}, 32'd1);
        tick(); chk("to_expired_pulse", {31'd0, expired_b[2]}, 32'd0);
        FORCE_VAL = 4'b0100; tick(); idle();
        tick(); chk("rearm_c2", {31'd0, forced_b[2]}, 32'd1);
        FORCE_VAL = 4'b0100; tick(); idle();
        tick(); tick(); chk("rearm_c3", {31'd0, forced_b[2]}, 32'd1);
        tick(); chk("rearm_released", {30'd0, expired_b[2], forced_b[2]}, 32'd2);
        RELEASE = 4'hF; tick(); idle();

        // 6. independence and reset mid-force
        LOAD = 4'b1011; DATA_IN = 32'h7700_6655; tick(); idle();
        FORCE_SET = 4'b0100; tick(); idle();
        chk("indep_others", state_a & 32'hFF00_FFFF, 32'h7700_6655);
        chk("indep_forced", {28'd0, forced_a}, 32'h4);
        RST = 1'b1; tick(); RST = 1'b0;
        chk("midrst_state", state_a, 32'h5A5A5A5A);
        chk("midrst_forced", {28'd0, forced_a | forced_b}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RST        = ($urandom_range(199) == 0);
            LOAD       = 4'($urandom);
            DATA_IN    = $urandom;
            FORCE_DATA = $urandom;
            for (int c = 0; c < NCH; c++) begin
                FORCE_CLR[c] = ($urandom_range(15) == 0);
                FORCE_SET[c] = ($urandom_range(15) == 0);
                FORCE_VAL[c] = ($urandom_range(11) == 0);
                RELEASE[c]   = ($urandom_range(7) == 0);
            end
            tick();
        end
        RST = 1'b0; idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
